// File: rtl/pr_pkg.sv
// Shared types and constants for the packet-filter region.
package pr_pkg;

    // Filter FSM state; the encoding is visible through the STATE register
    typedef enum logic [1:0] {
        ST_HEAD = 2'd0,
        ST_PASS = 2'd1,
        ST_DROP = 2'd2
    } pr_state_t;

    // Control register byte offsets
    localparam logic [7:0] REG_MAC_LO   = 8'h00;
    localparam logic [7:0] REG_MAC_HI   = 8'h04;
    localparam logic [7:0] REG_OBS_LO   = 8'h08;
    localparam logic [7:0] REG_OBS_HI   = 8'h0C;
    localparam logic [7:0] REG_PASS_CNT = 8'h10;
    localparam logic [7:0] REG_DROP_CNT = 8'h14;
    localparam logic [7:0] REG_STATE    = 8'h18;

    localparam logic [47:0] BROADCAST_MAC = 48'hffff_ffff_ffff;

    // Destination MAC from the first six wire bytes; wire byte 0 becomes MAC[47:40]
    function automatic logic [47:0] dest_mac(input logic [47:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24], d[39:32], d[47:40]};
    endfunction

endpackage

// File: rtl/pr_ctrl_regs.sv
// AXI4-Lite slave and register file: station MAC, observed MAC, frame counters, state.
module pr_ctrl_regs
    import pr_pkg::*;
#(
    parameter logic [47:0] DEFAULT_MAC = 48'hfa163e55ca02,
    parameter int unsigned CTRL_AW     = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [CTRL_AW-1:0] awaddr,
    input  logic               awvalid,
    output logic               awready,
    input  logic [31:0]        wdata,
    input  logic [3:0]         wstrb,
    input  logic               wvalid,
    output logic               wready,
    output logic               bvalid,
    output logic [1:0]         bresp,
    input  logic               bready,
    input  logic [CTRL_AW-1:0] araddr,
    input  logic               arvalid,
    output logic               arready,
    output logic               rvalid,
    output logic [31:0]        rdata,
    output logic [1:0]         rresp,
    input  logic               rready,
    output logic [47:0]        mac,
    input  logic [47:0]        obs_mac,
    input  logic               pass_inc,
    input  logic               drop_inc,
    input  pr_state_t          state
);

    logic [31:0] pass_cnt;
    logic [31:0] drop_cnt;
    logic [31:0] rd_word;
    logic        idle;
    logic        wr_go;
    logic        rd_go;
    logic        wr_lo;
    logic        wr_hi;

    function automatic logic hit(input logic [CTRL_AW-1:0] a, input logic [7:0] off);
        return a == CTRL_AW'(off);
    endfunction

    // One transaction at a time; a pending write blocks a simultaneous read
    assign idle  = !awready && !arready && !bvalid && !rvalid;
    assign wr_go = idle && awvalid && wvalid;
    assign rd_go = idle && arvalid && !(awvalid && wvalid);
    assign wr_lo = awready && hit(awaddr, REG_MAC_LO);
    assign wr_hi = awready && hit(awaddr, REG_MAC_HI);
    assign bresp = '0;
    assign rresp = '0;

    // Read data mux; unmapped offsets read as zero
    always_comb begin
        rd_word = '0;
        if (hit(araddr, REG_MAC_LO))        rd_word = mac[31:0];
        else if (hit(araddr, REG_MAC_HI))   rd_word = {16'h0, mac[47:32]};
        else if (hit(araddr, REG_OBS_LO))   rd_word = obs_mac[31:0];
        else if (hit(araddr, REG_OBS_HI))   rd_word = {16'h0, obs_mac[47:32]};
        else if (hit(araddr, REG_PASS_CNT)) rd_word = pass_cnt;
        else if (hit(araddr, REG_DROP_CNT)) rd_word = drop_cnt;
        else if (hit(araddr, REG_STATE))    rd_word = {30'h0, state};
    end

    // Handshake sequencing: ready pulses, then response held until accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awready <= 1'b0;
            wready  <= 1'b0;
            arready <= 1'b0;
            bvalid  <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
        end else begin
            awready <= wr_go;
            wready  <= wr_go;
            arready <= rd_go;
            if (awready)     bvalid <= 1'b1;
            else if (bready) bvalid <= 1'b0;
            if (arready) begin
                rvalid <= 1'b1;
                rdata  <= rd_word;
            end else if (rready) begin
                rvalid <= 1'b0;
            end
        end
    end

    // Register file: byte-strobed MAC writes and free-running frame counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mac      <= DEFAULT_MAC;
            pass_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < 4; i++)
                if (wr_lo && wstrb[i]) mac[8*i +: 8] <= wdata[8*i +: 8];
            for (int unsigned i = 0; i < 2; i++)
                if (wr_hi && wstrb[i]) mac[32+8*i +: 8] <= wdata[8*i +: 8];
            if (pass_inc) pass_cnt <= pass_cnt + 32'd1;
            if (drop_inc) drop_cnt <= drop_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/pr_region.sv
// Packet-filter region: forwards frames addressed to the station MAC or broadcast.
module pr_region
    import pr_pkg::*;
#(
    parameter logic [47:0] DEFAULT_MAC = 48'hfa163e55ca02,
    parameter int unsigned CTRL_AW     = 32
) (
    input  logic               CLK,
    input  logic               ARESETN,
    input  logic [63:0]        S_AXIS_tdata,
    input  logic [7:0]         S_AXIS_tkeep,
    input  logic               S_AXIS_tlast,
    input  logic               S_AXIS_tvalid,
    output logic               S_AXIS_tready,
    output logic [63:0]        M_AXIS_tdata,
    output logic [7:0]         M_AXIS_tkeep,
    output logic               M_AXIS_tlast,
    output logic               M_AXIS_tvalid,
    input  logic               M_AXIS_tready,
    input  logic [CTRL_AW-1:0] S_AXI_CONTROL_awaddr,
    input  logic               S_AXI_CONTROL_awvalid,
    output logic               S_AXI_CONTROL_awready,
    input  logic [31:0]        S_AXI_CONTROL_wdata,
    input  logic [3:0]         S_AXI_CONTROL_wstrb,
    input  logic               S_AXI_CONTROL_wvalid,
    output logic               S_AXI_CONTROL_wready,
    output logic               S_AXI_CONTROL_bvalid,
    output logic [1:0]         S_AXI_CONTROL_bresp,
    input  logic               S_AXI_CONTROL_bready,
    input  logic [CTRL_AW-1:0] S_AXI_CONTROL_araddr,
    input  logic               S_AXI_CONTROL_arvalid,
    output logic               S_AXI_CONTROL_arready,
    output logic               S_AXI_CONTROL_rvalid,
    output logic [31:0]        S_AXI_CONTROL_rdata,
    output logic [1:0]         S_AXI_CONTROL_rresp,
    input  logic               S_AXI_CONTROL_rready,
    output logic [31:0] S_AXI_MEM_0_awaddr,  output logic [7:0] S_AXI_MEM_0_awlen,
    output logic [2:0]  S_AXI_MEM_0_awsize,  output logic [1:0] S_AXI_MEM_0_awburst,
    output logic [3:0]  S_AXI_MEM_0_awcache, output logic       S_AXI_MEM_0_awlock,
    output logic [2:0]  S_AXI_MEM_0_awprot,  output logic [3:0] S_AXI_MEM_0_awqos,
    output logic        S_AXI_MEM_0_awvalid, input  logic       S_AXI_MEM_0_awready,
    output logic [63:0] S_AXI_MEM_0_wdata,   output logic [7:0] S_AXI_MEM_0_wstrb,
    output logic        S_AXI_MEM_0_wlast,   output logic       S_AXI_MEM_0_wvalid,
    input  logic        S_AXI_MEM_0_wready,  input  logic [1:0] S_AXI_MEM_0_bresp,
    input  logic        S_AXI_MEM_0_bvalid,  output logic       S_AXI_MEM_0_bready,
    output logic [31:0] S_AXI_MEM_0_araddr,  output logic [7:0] S_AXI_MEM_0_arlen,
    output logic [2:0]  S_AXI_MEM_0_arsize,  output logic [1:0] S_AXI_MEM_0_arburst,
    output logic [3:0]  S_AXI_MEM_0_arcache, output logic       S_AXI_MEM_0_arlock,
    output logic [2:0]  S_AXI_MEM_0_arprot,  output logic [3:0] S_AXI_MEM_0_arqos,
    output logic        S_AXI_MEM_0_arvalid, input  logic       S_AXI_MEM_0_arready,
    input  logic [63:0] S_AXI_MEM_0_rdata,   input  logic [1:0] S_AXI_MEM_0_rresp,
    input  logic        S_AXI_MEM_0_rlast,   input  logic       S_AXI_MEM_0_rvalid,
    output logic        S_AXI_MEM_0_rready,
    output logic [31:0] S_AXI_MEM_1_awaddr,  output logic [7:0] S_AXI_MEM_1_awlen,
    output logic [2:0]  S_AXI_MEM_1_awsize,  output logic [1:0] S_AXI_MEM_1_awburst,
    output logic [3:0]  S_AXI_MEM_1_awcache, output logic       S_AXI_MEM_1_awlock,
    output logic [2:0]  S_AXI_MEM_1_awprot,  output logic [3:0] S_AXI_MEM_1_awqos,
    output logic        S_AXI_MEM_1_awvalid, input  logic       S_AXI_MEM_1_awready,
    output logic [63:0] S_AXI_MEM_1_wdata,   output logic [7:0] S_AXI_MEM_1_wstrb,
    output logic        S_AXI_MEM_1_wlast,   output logic       S_AXI_MEM_1_wvalid,
    input  logic        S_AXI_MEM_1_wready,  input  logic [1:0] S_AXI_MEM_1_bresp,
    input  logic        S_AXI_MEM_1_bvalid,  output logic       S_AXI_MEM_1_bready,
    output logic [31:0] S_AXI_MEM_1_araddr,  output logic [7:0] S_AXI_MEM_1_arlen,
    output logic [2:0]  S_AXI_MEM_1_arsize,  output logic [1:0] S_AXI_MEM_1_arburst,
    output logic [3:0]  S_AXI_MEM_1_arcache, output logic       S_AXI_MEM_1_arlock,
    output logic [2:0]  S_AXI_MEM_1_arprot,  output logic [3:0] S_AXI_MEM_1_arqos,
    output logic        S_AXI_MEM_1_arvalid, input  logic       S_AXI_MEM_1_arready,
    input  logic [63:0] S_AXI_MEM_1_rdata,   input  logic [1:0] S_AXI_MEM_1_rresp,
    input  logic        S_AXI_MEM_1_rlast,   input  logic       S_AXI_MEM_1_rvalid,
    output logic        S_AXI_MEM_1_rready
);

    pr_state_t   state;
    logic        run;
    logic [47:0] mac;
    logic [47:0] obs_mac;
    logic [47:0] dest;
    logic        head_match;
    logic        accept;
    logic        fwd;
    logic        pass_inc;
    logic        drop_inc;
    logic        unused_mem;

    assign dest       = dest_mac(S_AXIS_tdata[47:0]);
    assign head_match = (S_AXIS_tkeep[5:0] == 6'h3f) && ((dest == mac) || (dest == BROADCAST_MAC));
    // DROP never loads the output register, so it can sink flits regardless of backpressure
    assign S_AXIS_tready = run && ((state == ST_DROP) || !M_AXIS_tvalid || M_AXIS_tready);
    assign accept        = S_AXIS_tvalid && S_AXIS_tready;

    // Whether the flit on the input is to be forwarded
    always_comb begin
        fwd = 1'b0;
        case (state)
            ST_HEAD: fwd = head_match;
            ST_PASS: fwd = 1'b1;
            default: fwd = 1'b0;
        endcase
    end

    // Filter FSM; head decisions latch the observed MAC and pulse a counter
    always_ff @(posedge CLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state    <= ST_HEAD;
            run      <= 1'b0;
            obs_mac  <= '0;
            pass_inc <= 1'b0;
            drop_inc <= 1'b0;
        end else begin
            run      <= 1'b1;
            pass_inc <= 1'b0;
            drop_inc <= 1'b0;
            if (accept) begin
                case (state)
                    ST_HEAD: begin
                        obs_mac  <= dest;
                        pass_inc <= head_match;
                        drop_inc <= !head_match;
                        if (!S_AXIS_tlast) state <= head_match ? ST_PASS : ST_DROP;
                    end
                    ST_PASS, ST_DROP: if (S_AXIS_tlast) state <= ST_HEAD;
                    default: state <= ST_HEAD;
                endcase
            end
        end
    end

    // One-entry output register; payload held while stalled
    always_ff @(posedge CLK or negedge ARESETN) begin
        if (!ARESETN) begin
            M_AXIS_tvalid <= 1'b0;
            M_AXIS_tdata  <= '0;
            M_AXIS_tkeep  <= '0;
            M_AXIS_tlast  <= 1'b0;
        end else if (accept && fwd) begin
            M_AXIS_tvalid <= 1'b1;
            M_AXIS_tdata  <= S_AXIS_tdata;
            M_AXIS_tkeep  <= S_AXIS_tkeep;
            M_AXIS_tlast  <= S_AXIS_tlast;
        end else if (M_AXIS_tready) begin
            M_AXIS_tvalid <= 1'b0;
        end
    end

    pr_ctrl_regs #(
        .DEFAULT_MAC (DEFAULT_MAC),
        .CTRL_AW     (CTRL_AW)
    ) u_ctrl (
        .clk      (CLK),
        .rst_n    (ARESETN),
        .awaddr   (S_AXI_CONTROL_awaddr),
        .awvalid  (S_AXI_CONTROL_awvalid),
        .awready  (S_AXI_CONTROL_awready),
        .wdata    (S_AXI_CONTROL_wdata),
        .wstrb    (S_AXI_CONTROL_wstrb),
        .wvalid   (S_AXI_CONTROL_wvalid),
        .wready   (S_AXI_CONTROL_wready),
        .bvalid   (S_AXI_CONTROL_bvalid),
        .bresp    (S_AXI_CONTROL_bresp),
        .bready   (S_AXI_CONTROL_bready),
        .araddr   (S_AXI_CONTROL_araddr),
        .arvalid  (S_AXI_CONTROL_arvalid),
        .arready  (S_AXI_CONTROL_arready),
        .rvalid   (S_AXI_CONTROL_rvalid),
        .rdata    (S_AXI_CONTROL_rdata),
        .rresp    (S_AXI_CONTROL_rresp),
        .rready   (S_AXI_CONTROL_rready),
        .mac      (mac),
        .obs_mac  (obs_mac),
        .pass_inc (pass_inc),
        .drop_inc (drop_inc),
        .state    (state)
    );

    // Reserved memory ports held idle
    assign {S_AXI_MEM_0_awaddr, S_AXI_MEM_0_awlen, S_AXI_MEM_0_awsize, S_AXI_MEM_0_awburst,
            S_AXI_MEM_0_awcache, S_AXI_MEM_0_awlock, S_AXI_MEM_0_awprot, S_AXI_MEM_0_awqos,
            S_AXI_MEM_0_awvalid} = '0;
    assign {S_AXI_MEM_0_wdata, S_AXI_MEM_0_wstrb, S_AXI_MEM_0_wlast, S_AXI_MEM_0_wvalid} = '0;
    assign {S_AXI_MEM_0_araddr, S_AXI_MEM_0_arlen, S_AXI_MEM_0_arsize, S_AXI_MEM_0_arburst,
            S_AXI_MEM_0_arcache, S_AXI_MEM_0_arlock, S_AXI_MEM_0_arprot, S_AXI_MEM_0_arqos,
            S_AXI_MEM_0_arvalid} = '0;
    assign S_AXI_MEM_0_bready = 1'b1;
    assign S_AXI_MEM_0_rready = 1'b1;
    assign {S_AXI_MEM_1_awaddr, S_AXI_MEM_1_awlen, S_AXI_MEM_1_awsize, S_AXI_MEM_1_awburst,
            S_AXI_MEM_1_awcache, S_AXI_MEM_1_awlock, S_AXI_MEM_1_awprot, S_AXI_MEM_1_awqos,
            S_AXI_MEM_1_awvalid} = '0;
    assign {S_AXI_MEM_1_wdata, S_AXI_MEM_1_wstrb, S_AXI_MEM_1_wlast, S_AXI_MEM_1_wvalid} = '0;
    assign {S_AXI_MEM_1_araddr, S_AXI_MEM_1_arlen, S_AXI_MEM_1_arsize, S_AXI_MEM_1_arburst,
            S_AXI_MEM_1_arcache, S_AXI_MEM_1_arlock, S_AXI_MEM_1_arprot, S_AXI_MEM_1_arqos,
            S_AXI_MEM_1_arvalid} = '0;
    assign S_AXI_MEM_1_bready = 1'b1;
    assign S_AXI_MEM_1_rready = 1'b1;

    assign unused_mem = ^{S_AXI_MEM_0_awready, S_AXI_MEM_0_wready, S_AXI_MEM_0_bresp,
                          S_AXI_MEM_0_bvalid, S_AXI_MEM_0_arready, S_AXI_MEM_0_rdata,
                          S_AXI_MEM_0_rresp, S_AXI_MEM_0_rlast, S_AXI_MEM_0_rvalid,
                          S_AXI_MEM_1_awready, S_AXI_MEM_1_wready, S_AXI_MEM_1_bresp,
                          S_AXI_MEM_1_bvalid, S_AXI_MEM_1_arready, S_AXI_MEM_1_rdata,
                          S_AXI_MEM_1_rresp, S_AXI_MEM_1_rlast, S_AXI_MEM_1_rvalid};

endmodule

// File: tb/tb_pr_region.sv
// Scoreboard bench for pr_region: directed plan cases followed by randomized frames.
`timescale 1ns/1ps
module tb_pr_region;

    localparam logic [47:0] DEF_MAC = 48'hfa163e55ca02;
    localparam logic [47:0] BCAST   = 48'hffff_ffff_ffff;

    logic        CLK = 1'b0;
    logic        ARESETN;
    logic [63:0] S_AXIS_tdata;
    logic [7:0]  S_AXIS_tkeep;
    logic        S_AXIS_tlast, S_AXIS_tvalid, S_AXIS_tready;
    logic [63:0] M_AXIS_tdata;
    logic [7:0]  M_AXIS_tkeep;
    logic        M_AXIS_tlast, M_AXIS_tvalid, M_AXIS_tready;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;
    // Memory port outputs (master side) and tied-off inputs, two ports
    logic [31:0] m_awaddr [2], m_araddr [2];
    logic [7:0]  m_awlen [2], m_arlen [2], m_wstrb [2];
    logic [2:0]  m_awsize [2], m_arsize [2], m_awprot [2], m_arprot [2];
    logic [1:0]  m_awburst [2], m_arburst [2];
    logic [3:0]  m_awcache [2], m_arcache [2], m_awqos [2], m_arqos [2];
    logic        m_awlock [2], m_arlock [2], m_awvalid [2], m_arvalid [2], m_wlast [2], m_wvalid [2];
    logic        m_bready [2], m_rready [2];
    logic [63:0] m_wdata [2];
    logic [63:0] mem_rdata = '0;
    logic [1:0]  mem_resp = '0;
    logic        mem_in = 1'b0;

    int checks = 0;
    int failures = 0;
    int bp_mode = 0;       // 0: always ready, 1: random, 2: stalled
    int total_wait = 0;

    logic [72:0] exp_q[$];
    logic        hold_prev = 1'b0;
    logic [72:0] prev_out;

    logic [63:0] fd [8];
    logic [7:0]  fk [8];

    // Reference model state
    logic [47:0] m_mac;
    logic [47:0] m_obs;
    logic [31:0] m_pass, m_drop;

    initial forever #5 CLK = ~CLK;

    pr_region #(.DEFAULT_MAC(DEF_MAC), .CTRL_AW(32)) dut (
        .CLK(CLK), .ARESETN(ARESETN),
        .S_AXIS_tdata(S_AXIS_tdata), .S_AXIS_tkeep(S_AXIS_tkeep), .S_AXIS_tlast(S_AXIS_tlast),
        .S_AXIS_tvalid(S_AXIS_tvalid), .S_AXIS_tready(S_AXIS_tready),
        .M_AXIS_tdata(M_AXIS_tdata), .M_AXIS_tkeep(M_AXIS_tkeep), .M_AXIS_tlast(M_AXIS_tlast),
        .M_AXIS_tvalid(M_AXIS_tvalid), .M_AXIS_tready(M_AXIS_tready),
        .S_AXI_CONTROL_awaddr(awaddr), .S_AXI_CONTROL_awvalid(awvalid), .S_AXI_CONTROL_awready(awready),
        .S_AXI_CONTROL_wdata(wdata), .S_AXI_CONTROL_wstrb(wstrb), .S_AXI_CONTROL_wvalid(wvalid),
        .S_AXI_CONTROL_wready(wready), .S_AXI_CONTROL_bvalid(bvalid), .S_AXI_CONTROL_bresp(bresp),
        .S_AXI_CONTROL_bready(bready), .S_AXI_CONTROL_araddr(araddr), .S_AXI_CONTROL_arvalid(arvalid),
        .S_AXI_CONTROL_arready(arready), .S_AXI_CONTROL_rvalid(rvalid), .S_AXI_CONTROL_rdata(rdata),
        .S_AXI_CONTROL_rresp(rresp), .S_AXI_CONTROL_rready(rready),
        .S_AXI_MEM_0_awaddr(m_awaddr[0]), .S_AXI_MEM_0_awlen(m_awlen[0]), .S_AXI_MEM_0_awsize(m_awsize[0]),
        .S_AXI_MEM_0_awburst(m_awburst[0]), .S_AXI_MEM_0_awcache(m_awcache[0]), .S_AXI_MEM_0_awlock(m_awlock[0]),
        .S_AXI_MEM_0_awprot(m_awprot[0]), .S_AXI_MEM_0_awqos(m_awqos[0]), .S_AXI_MEM_0_awvalid(m_awvalid[0]),
        .S_AXI_MEM_0_awready(mem_in), .S_AXI_MEM_0_wdata(m_wdata[0]), .S_AXI_MEM_0_wstrb(m_wstrb[0]),
        .S_AXI_MEM_0_wlast(m_wlast[0]), .S_AXI_MEM_0_wvalid(m_wvalid[0]), .S_AXI_MEM_0_wready(mem_in),
        .S_AXI_MEM_0_bresp(mem_resp), .S_AXI_MEM_0_bvalid(mem_in), .S_AXI_MEM_0_bready(m_bready[0]),
        .S_AXI_MEM_0_araddr(m_araddr[0]), .S_AXI_MEM_0_arlen(m_arlen[0]), .S_AXI_MEM_0_arsize(m_arsize[0]),
        .S_AXI_MEM_0_arburst(m_arburst[0]), .S_AXI_MEM_0_arcache(m_arcache[0]), .S_AXI_MEM_0_arlock(m_arlock[0]),
        .S_AXI_MEM_0_arprot(m_arprot[0]), .S_AXI_MEM_0_arqos(m_arqos[0]), .S_AXI_MEM_0_arvalid(m_arvalid[0]),
        .S_AXI_MEM_0_arready(mem_in), .S_AXI_MEM_0_rdata(mem_rdata), .S_AXI_MEM_0_rresp(mem_resp),
        .S_AXI_MEM_0_rlast(mem_in), .S_AXI_MEM_0_rvalid(mem_in), .S_AXI_MEM_0_rready(m_rready[0]),
        .S_AXI_MEM_1_awaddr(m_awaddr[1]), .S_AXI_MEM_1_awlen(m_awlen[1]), .S_AXI_MEM_1_awsize(m_awsize[1]),
        .S_AXI_MEM_1_awburst(m_awburst[1]), .S_AXI_MEM_1_awcache(m_awcache[1]), .S_AXI_MEM_1_awlock(m_awlock[1]),
        .S_AXI_MEM_1_awprot(m_awprot[1]), .S_AXI_MEM_1_awqos(m_awqos[1]), .S_AXI_MEM_1_awvalid(m_awvalid[1]),
        .S_AXI_MEM_1_awready(mem_in), .S_AXI_MEM_1_wdata(m_wdata[1]), .S_AXI_MEM_1_wstrb(m_wstrb[1]),
        .S_AXI_MEM_1_wlast(m_wlast[1]), .S_AXI_MEM_1_wvalid(m_wvalid[1]), .S_AXI_MEM_1_wready(mem_in),
        .S_AXI_MEM_1_bresp(mem_resp), .S_AXI_MEM_1_bvalid(mem_in), .S_AXI_MEM_1_bready(m_bready[1]),
        .S_AXI_MEM_1_araddr(m_araddr[1]), .S_AXI_MEM_1_arlen(m_arlen[1]), .S_AXI_MEM_1_arsize(m_arsize[1]),
        .S_AXI_MEM_1_arburst(m_arburst[1]), .S_AXI_MEM_1_arcache(m_arcache[1]), .S_AXI_MEM_1_arlock(m_arlock[1]),
        .S_AXI_MEM_1_arprot(m_arprot[1]), .S_AXI_MEM_1_arqos(m_arqos[1]), .S_AXI_MEM_1_arvalid(m_arvalid[1]),
        .S_AXI_MEM_1_arready(mem_in), .S_AXI_MEM_1_rdata(mem_rdata), .S_AXI_MEM_1_rresp(mem_resp),
        .S_AXI_MEM_1_rlast(mem_in), .S_AXI_MEM_1_rvalid(mem_in), .S_AXI_MEM_1_rready(m_rready[1])
    );

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout expected=handshake (t=%0t)", name, $time);
    endtask

    // Wire byte b is data[8b+:8]; the first wire byte is the most significant MAC byte
    function automatic logic [47:0] model_dest(input logic [63:0] d);
        logic [47:0] m;
        for (int b = 0; b < 6; b++) m[47-8*b -: 8] = d[8*b +: 8];
        return m;
    endfunction

    // Downstream ready generator
    initial begin
        M_AXIS_tready = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            if (bp_mode == 0)      M_AXIS_tready = 1'b1;
            else if (bp_mode == 2) M_AXIS_tready = 1'b0;
            else                   M_AXIS_tready = ($urandom_range(0, 3) != 0);
        end
    end

    // Output monitor: pops the scoreboard on every transfer and checks stall stability
    always @(negedge CLK) begin
        logic [72:0] cur;
        logic [72:0] e;
        cur = {M_AXIS_tdata, M_AXIS_tkeep, M_AXIS_tlast};
        if (ARESETN) begin
            if (hold_prev) chk("hold_stable", {M_AXIS_tvalid, cur}, {1'b1, prev_out});
            if (M_AXIS_tvalid && M_AXIS_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", {1'b1, cur}, 80'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_flit", cur, e);
                end
            end
            hold_prev = M_AXIS_tvalid && !M_AXIS_tready;
            prev_out  = cur;
        end else begin
            hold_prev = 1'b0;
        end
    end

    task automatic send_flit(input logic [63:0] d, input logic [7:0] k, input logic l);
        int w;
        S_AXIS_tdata  = d;
        S_AXIS_tkeep  = k;
        S_AXIS_tlast  = l;
        S_AXIS_tvalid = 1'b1;
        w = 0;
        forever begin
            @(negedge CLK);
            if (S_AXIS_tready) break;
            w++;
            if (w > 200) begin
                fail_now("s_axis_accept");
                break;
            end
        end
        total_wait += w;
        @(posedge CLK);
        #1;
        S_AXIS_tvalid = 1'b0;
    endtask

    // Frame-level reference: pass if six head bytes are kept and dest is station or broadcast
    task automatic send_frame(input int n, input int gap_max);
        logic [47:0] dest;
        bit pass;
        dest  = model_dest(fd[0]);
        pass  = (fk[0][5:0] == 6'h3f) && (dest == m_mac || dest == BCAST);
        m_obs = dest;
        if (pass) m_pass++;
        else      m_drop++;
        for (int i = 0; i < n; i++) begin
            if (pass) exp_q.push_back({fd[i], fk[i], (i == n - 1)});
            send_flit(fd[i], fk[i], (i == n - 1));
            repeat ($urandom_range(0, gap_max)) begin
                @(posedge CLK);
                #1;
            end
        end
    endtask

    task automatic axil_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int t;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        for (t = 0; t < 50; t++) begin
            @(negedge CLK);
            if (awready) break;
        end
        if (t == 50) fail_now("axil_awready");
        else chk("axil_wready_with_aw", wready, 1'b1);
        @(posedge CLK);
        #1;
        awvalid = 1'b0; wvalid = 1'b0;
        for (t = 0; t < 50; t++) begin
            @(negedge CLK);
            if (bvalid) break;
        end
        if (t == 50) fail_now("axil_bvalid");
        else chk("axil_bresp", bresp, 2'b00);
        @(posedge CLK);
        #1;
    endtask

    task automatic axil_read(input logic [31:0] a, output logic [31:0] d);
        int t;
        d = '0;
        araddr = a;
        arvalid = 1'b1;
        for (t = 0; t < 50; t++) begin
            @(negedge CLK);
            if (arready) break;
        end
        if (t == 50) fail_now("axil_arready");
        @(posedge CLK);
        #1;
        arvalid = 1'b0;
        for (t = 0; t < 50; t++) begin
            @(negedge CLK);
            if (rvalid) break;
        end
        if (t == 50) fail_now("axil_rvalid");
        else begin
            d = rdata;
            chk("axil_rresp", rresp, 2'b00);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic reg_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] v;
        axil_read(a, v);
        chk(name, v, exp);
    endtask

    task automatic check_regs();
        reg_check("pass_cnt", 32'h10, m_pass);
        reg_check("drop_cnt", 32'h14, m_drop);
        reg_check("obs_lo", 32'h08, m_obs[31:0]);
        reg_check("obs_hi", 32'h0C, {16'h0, m_obs[47:32]});
        reg_check("state_idle", 32'h18, 32'd0);
    endtask

    task automatic drain();
        int t;
        for (t = 0; t < 2000; t++) begin
            @(negedge CLK);
            if (exp_q.size() == 0 && !M_AXIS_tvalid) break;
        end
        if (t == 2000) fail_now("drain_output");
    endtask

    task automatic load_a();
        fd[0] = 64'h4c0c02ca553e16fa; fk[0] = 8'hff;
        fd[1] = 64'h0000007447c0887a; fk[1] = 8'hff;
        fd[2] = 64'h0100000100030000; fk[2] = 8'hff;
        fd[3] = 64'h5073930200000000; fk[3] = 8'h0f;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished (t=%0t)", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        logic [63:0] r;
        logic [47:0] dest;
        int len, sel;
        ARESETN = 1'b0;
        S_AXIS_tdata = '0; S_AXIS_tkeep = '0; S_AXIS_tlast = 1'b0; S_AXIS_tvalid = 1'b0;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
        m_mac = DEF_MAC; m_obs = '0; m_pass = '0; m_drop = '0;

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_s_ready", S_AXIS_tready, 1'b0);
        chk("rst_m_out", {M_AXIS_tvalid, M_AXIS_tdata, M_AXIS_tkeep, M_AXIS_tlast}, '0);
        chk("rst_ctrl_hs", {awready, wready, bvalid, arready, rvalid}, '0);
        chk("mem_valids", {m_awvalid[0], m_wvalid[0], m_arvalid[0], m_awvalid[1], m_wvalid[1], m_arvalid[1]}, '0);
        chk("mem_readies", {m_bready[0], m_rready[0], m_bready[1], m_rready[1]}, 4'hf);
        chk("mem_addr", {m_awaddr[0], m_araddr[1], m_wdata[0], m_wstrb[1]}, '0);
        ARESETN = 1'b1;
        @(negedge CLK);
        chk("s_ready_before_first_edge", S_AXIS_tready, 1'b0);
        @(negedge CLK);
        chk("s_ready_after_first_edge", S_AXIS_tready, 1'b1);
        @(posedge CLK);
        #1;
        reg_check("mac_lo_default", 32'h00, 32'h3e55ca02);
        reg_check("mac_hi_default", 32'h04, 32'h0000fa16);
        check_regs();

        // Matching frame forwarded unchanged
        load_a();
        send_frame(4, 0);
        drain();
        check_regs();
        reg_check("obs_hi_plan", 32'h0C, 32'h0000fa16);
        reg_check("obs_lo_plan", 32'h08, 32'h3e55ca02);

        // Non-matching frame dropped without ever stalling the input
        fd[0][7:0] = 8'hfb;
        total_wait = 0;
        send_frame(4, 0);
        chk("drop_no_stall", total_wait, 0);
        drain();
        check_regs();

        // Broadcast frame
        load_a();
        fd[0][47:0] = '1;
        send_frame(4, 0);
        drain();
        check_regs();

        // Reprogrammed MAC: old address dropped, new address forwarded
        axil_write(32'h04, 32'h0000fb16, 4'hf);
        m_mac[47:32] = 16'hfb16;
        reg_check("mac_hi_written", 32'h04, 32'h0000fb16);
        load_a();
        send_frame(4, 1);
        fd[0][7:0] = 8'hfb;
        send_frame(4, 1);
        drain();
        check_regs();
        // Byte strobe, RO write ignored, unmapped read
        axil_write(32'h00, 32'haaaaaa11, 4'b0001);
        m_mac[7:0] = 8'h11;
        reg_check("mac_lo_strobe", 32'h00, 32'h3e55ca11);
        axil_write(32'h10, 32'h12345678, 4'hf);
        reg_check("pass_cnt_ro", 32'h10, m_pass);
        reg_check("unmapped_read", 32'h1C, 32'h0);
        axil_write(32'h00, 32'h3e55ca02, 4'hf);
        axil_write(32'h04, 32'hffb1fa16, 4'b0011);
        m_mac = DEF_MAC;
        reg_check("mac_hi_restored", 32'h04, 32'h0000fa16);

        // Downstream stall mid-frame
        bp_mode = 2;
        repeat (2) begin @(posedge CLK); #1; end
        load_a();
        fork
            send_frame(4, 0);
            begin
                repeat (2) @(negedge CLK);
                for (int i = 0; i < 5; i++) begin
                    chk("stall_s_ready", S_AXIS_tready, 1'b0);
                    chk("stall_m_hold", {M_AXIS_tvalid, M_AXIS_tdata}, {1'b1, fd[0]});
                    @(negedge CLK);
                end
                bp_mode = 0;
            end
        join
        drain();
        check_regs();

        // Reset in the middle of a frame: flit 1 is still in the output register
        load_a();
        exp_q.push_back({fd[0], fk[0], 1'b0});
        send_flit(fd[0], fk[0], 1'b0);
        send_flit(fd[1], fk[1], 1'b0);
        ARESETN = 1'b0;
        #2;
        chk("midrst_m_out", {M_AXIS_tvalid, M_AXIS_tdata}, '0);
        chk("midrst_q_empty", exp_q.size(), 0);
        m_pass = '0; m_drop = '0; m_obs = '0; m_mac = DEF_MAC;
        @(posedge CLK);
        #1;
        ARESETN = 1'b1;
        check_regs();
        // Remainder of the aborted frame is seen as a new (non-matching) frame
        fd[0] = fd[2]; fd[1] = fd[3]; fk[1] = fk[3];
        send_frame(2, 0);
        load_a();
        send_frame(4, 0);
        drain();
        check_regs();

        // Randomized frames under random backpressure
        bp_mode = 1;
        for (int f = 0; f < 40; f++) begin
            len = $urandom_range(1, 5);
            sel = $urandom_range(0, 3);
            r = {$urandom(), $urandom()};
            case (sel)
                0: dest = m_mac;
                1: dest = BCAST;
                2: dest = r[47:0];
                default: dest = m_mac ^ (48'h1 << $urandom_range(0, 47));
            endcase
            r = {$urandom(), $urandom()};
            for (int b = 0; b < 6; b++) r[8*b +: 8] = dest[47-8*b -: 8];
            fd[0] = r;
            for (int i = 1; i < len; i++) fd[i] = {$urandom(), $urandom()};
            for (int i = 0; i < len; i++) fk[i] = 8'hff;
            fk[len-1] = 8'($urandom_range(1, 255));
            if ($urandom_range(0, 5) == 0) fk[0] = 8'h1f;
            send_frame(len, 2);
        end
        bp_mode = 0;
        drain();
        check_regs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
